// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a program image over UART and writes it into
// SDRAM word by word, then releases the core through init_finish.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   uart_rx          serial input, idle high, 8N1, LSB first
//   sdram_enable     write request; sdram_addr/sdram_wdata held until ready
//   sdram_addr       byte address of the word being written
//   sdram_write      1 while a request is active
//   sdram_wdata      word being written
//   sdram_dwidth     constant 2'b10 (32-bit access)
//   sdram_ready      controller completion pulse
//   init_finish      image loaded and checksum passed (sticky)
//   load_error       framing, checksum or overrun error (sticky)
//   words_loaded     words acknowledged by the controller
module uart_boot_loader #(
    parameter int          CLK_HZ       = 25000000,
    parameter int          BAUD         = 115200,
    parameter int          CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter logic [23:0] LOAD_BASE    = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        sdram_enable,
    output logic [23:0] sdram_addr,
    output logic        sdram_write,
    output logic [31:0] sdram_wdata,
    output logic [1:0]  sdram_dwidth,
    input  logic        sdram_ready,
    output logic        init_finish,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]  MAGIC    = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE
    } state_t;

    // ---------------- UART receiver ----------------
    logic      rx_s1, rx_s2, rx_d;
    rx_state_t rx_state, rx_next;
    logic [15:0] rx_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_byte;
    logic        rx_fall;
    logic        cnt_clr, shift_en, rx_valid, frame_err;

    assign rx_fall = rx_d & ~rx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rx_state <= RX_IDLE;
        else
            rx_state <= rx_next;
    end

    always_comb begin
        rx_next   = rx_state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        rx_valid  = 1'b0;
        frame_err = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_next = RX_START;
                    cnt_clr = 1'b1;
                end
            end
            RX_START: begin
                // Line back high at mid start bit: a glitch, not a frame.
                if (rx_cnt == HALF_END) begin
                    cnt_clr = 1'b1;
                    rx_next = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_END) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7)
                        rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_END) begin
                    rx_next   = RX_IDLE;
                    rx_valid  = rx_s2;
                    frame_err = ~rx_s2;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt  <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
        end else begin
            rx_cnt <= cnt_clr ? 16'd0 : rx_cnt + 16'd1;
            if (rx_state == RX_START)
                bit_idx <= '0;
            if (shift_en) begin
                rx_byte <= {rx_s2, rx_byte[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // ---------------- Load protocol ----------------
    state_t      state, state_next;
    logic [15:0] len;
    logic [15:0] words_rcvd;
    logic [1:0]  byte_cnt;
    logic [23:0] stage;
    logic [7:0]  csum;
    logic        ack, pending, all_rcvd;
    logic        take_byte, overrun, cks_bad, abort;

    assign ack          = sdram_enable & sdram_ready;
    assign pending      = sdram_enable & ~sdram_ready;
    assign all_rcvd     = (words_rcvd == len);
    assign sdram_write  = sdram_enable;
    assign sdram_dwidth = 2'b10;
    assign init_finish  = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        take_byte  = (state == S_DATA) && rx_valid && !all_rcvd;
        // A completed word while the previous write is still pending
        // has nowhere to go.
        overrun    = take_byte && (byte_cnt == 2'd3) && pending;
        cks_bad    = (state == S_CHECK) && rx_valid && (rx_byte != csum);
        abort      = overrun | cks_bad | (frame_err && state != S_DONE);
        unique case (state)
            S_IDLE:
                if (rx_valid && rx_byte == MAGIC)
                    state_next = S_LEN_LO;
            S_LEN_LO:
                if (rx_valid)
                    state_next = S_LEN_HI;
            S_LEN_HI:
                if (rx_valid)
                    state_next = ({rx_byte, len[7:0]} == 16'd0)
                                 ? S_CHECK : S_DATA;
            S_DATA:
                if (all_rcvd && !sdram_enable)
                    state_next = S_CHECK;
            S_CHECK:
                if (rx_valid && !cks_bad)
                    state_next = S_DONE;
            S_DONE:
                state_next = S_DONE;
            default:
                state_next = S_IDLE;
        endcase
        if (abort)
            state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdram_enable <= 1'b0;
            sdram_addr   <= LOAD_BASE;
            sdram_wdata  <= '0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            len          <= '0;
            words_rcvd   <= '0;
            byte_cnt     <= '0;
            stage        <= '0;
            csum         <= '0;
        end else begin
            if (ack) begin
                sdram_enable <= 1'b0;
                words_loaded <= words_loaded + 16'd1;
                sdram_addr   <= sdram_addr + 24'd4;
            end
            unique case (state)
                S_IDLE: begin
                    if (rx_valid && rx_byte == MAGIC) begin
                        load_error   <= 1'b0;
                        words_loaded <= '0;
                        sdram_addr   <= LOAD_BASE;
                        csum         <= '0;
                        words_rcvd   <= '0;
                        byte_cnt     <= '0;
                        len          <= '0;
                    end
                end
                S_LEN_LO:
                    if (rx_valid)
                        len[7:0] <= rx_byte;
                S_LEN_HI:
                    if (rx_valid)
                        len[15:8] <= rx_byte;
                S_DATA: begin
                    if (take_byte && !overrun) begin
                        csum     <= csum ^ rx_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        unique case (byte_cnt)
                            2'd0: stage[7:0]   <= rx_byte;
                            2'd1: stage[15:8]  <= rx_byte;
                            2'd2: stage[23:16] <= rx_byte;
                            2'd3: begin
                                sdram_wdata  <= {rx_byte, stage};
                                sdram_enable <= 1'b1;
                                words_rcvd   <= words_rcvd + 16'd1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
            if (abort) begin
                load_error   <= 1'b1;
                sdram_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: drives UART images, models the SDRAM
// controller and checks every write against a queue of expected words.
module tb_uart_boot_loader;

    localparam int CPB = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic        sdram_enable;
    logic [23:0] sdram_addr;
    logic        sdram_write;
    logic [31:0] sdram_wdata;
    logic [1:0]  sdram_dwidth;
    logic        sdram_ready;
    logic        init_finish;
    logic        load_error;
    logic [15:0] words_loaded;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  req_cnt = 0;
    int  ready_delay = 2;

    uart_boot_loader #(
        .CLK_HZ   (3200000),
        .BAUD     (100000),
        .LOAD_BASE(24'h000000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .sdram_enable(sdram_enable),
        .sdram_addr  (sdram_addr),
        .sdram_write (sdram_write),
        .sdram_wdata (sdram_wdata),
        .sdram_dwidth(sdram_dwidth),
        .sdram_ready (sdram_ready),
        .init_finish (init_finish),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_image(input int n, input logic [31:0] w[4],
                              input bit corrupt);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        send_byte(8'hA5);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: 24'(4 * i), data: w[i]});
            for (int k = 0; k < 4; k++) begin
                b = 8'(w[i] >> (8 * k));
                cs = cs ^ b;
                send_byte(b);
            end
        end
        send_byte(corrupt ? 8'h00 : cs);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !sdram_enable)
                break;
            @(negedge clk);
        end
        check("drain", 64'(exp_q.size()), 0);
    endtask

    // SDRAM controller model
    initial begin
        wr_t         e;
        logic [23:0] a;
        logic [31:0] d;
        logic [15:0] wl0;
        sdram_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sdram_enable && !rst) begin
                req_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", {sdram_addr, sdram_wdata}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", sdram_addr, e.addr);
                    check("wr_data", sdram_wdata, e.data);
                end
                check("wr_dwidth", sdram_dwidth, 2'b10);
                check("wr_write", sdram_write, 1'b1);
                a = sdram_addr;
                d = sdram_wdata;
                for (int i = 0; i < ready_delay && !rst; i++) begin
                    @(posedge clk);
                    #1;
                    if (!rst)
                        check("hold", {sdram_enable, sdram_addr, sdram_wdata},
                              {1'b1, a, d});
                end
                if (!rst) begin
                    wl0 = words_loaded;
                    sdram_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    sdram_ready = 1'b0;
                    check("wl_inc", words_loaded, wl0 + 16'd1);
                    check("en_drop", sdram_enable, 1'b0);
                end
            end
        end
    end

    initial begin
        logic [31:0] w[4];
        int          r0;
        rst = 1'b1;
        uart_rx = 1'b1;
        w = '{default: 32'h0};
        repeat (4) @(negedge clk);
        #1;
        check("rst_en", sdram_enable, 1'b0);
        check("rst_addr", sdram_addr, 24'h0);
        check("rst_wdata", sdram_wdata, 32'h0);
        check("rst_dw", sdram_dwidth, 2'b10);
        check("rst_init", init_finish, 1'b0);
        check("rst_err", load_error, 1'b0);
        check("rst_wl", words_loaded, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // two-word image, short controller latency
        w[0] = 32'h00000013;
        w[1] = 32'hDEADBEEF;
        send_image(2, w, 1'b0);
        wait_drain();
        repeat (4) @(negedge clk);
        check("t1_wl", words_loaded, 16'd2);
        check("t1_init", init_finish, 1'b1);
        check("t1_err", load_error, 1'b0);

        // 40-cycle controller latency
        do_reset();
        ready_delay = 40;
        w[0] = 32'h0BADF00D;
        w[1] = 32'h76543210;
        send_image(2, w, 1'b0);
        wait_drain();
        repeat (4) @(negedge clk);
        check("t2_wl", words_loaded, 16'd2);
        check("t2_init", init_finish, 1'b1);

        // bad checksum, then recovery
        do_reset();
        ready_delay = 2;
        w[0] = 32'h12345678;
        send_image(1, w, 1'b1);
        wait_drain();
        repeat (4) @(negedge clk);
        check("t3_err", load_error, 1'b1);
        check("t3_init", init_finish, 1'b0);
        w[0] = 32'hA1B2C3D4;
        send_image(1, w, 1'b0);
        wait_drain();
        repeat (4) @(negedge clk);
        check("t3b_err", load_error, 1'b0);
        check("t3b_init", init_finish, 1'b1);
        check("t3b_wl", words_loaded, 16'd1);

        // framing error on LEN_LO, then junk
        do_reset();
        r0 = req_cnt;
        send_byte(8'hA5);
        send_byte(8'h02, 1'b0);
        check("t4_err", load_error, 1'b1);
        send_byte(8'h55);
        send_byte(8'hFF);
        repeat (4) @(negedge clk);
        check("t4_req", 64'(req_cnt), 64'(r0));
        check("t4_err2", load_error, 1'b1);
        check("t4_init", init_finish, 1'b0);

        // empty image straight from IDLE
        send_image(0, w, 1'b0);
        repeat (4) @(negedge clk);
        check("t5_req", 64'(req_cnt), 64'(r0));
        check("t5_wl", words_loaded, 16'd0);
        check("t5_init", init_finish, 1'b1);
        check("t5_err", load_error, 1'b0);

        // reset while a write is pending
        do_reset();
        ready_delay = 1000;
        w[0] = 32'hCAFEF00D;
        exp_q.push_back('{addr: 24'h0, data: w[0]});
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < 4; k++)
            send_byte(8'(w[0] >> (8 * k)));
        for (int i = 0; i < 100; i++) begin
            if (sdram_enable)
                break;
            @(negedge clk);
        end
        check("t6_en", sdram_enable, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_en0", sdram_enable, 1'b0);
        check("t6_addr", sdram_addr, 24'h0);
        check("t6_wdata", sdram_wdata, 32'h0);
        check("t6_wl", words_loaded, 16'h0);
        check("t6_init", init_finish, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        ready_delay = 2;
        repeat (5) @(negedge clk);
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
        send_image(0, w, 1'b0);
        repeat (4) @(negedge clk);
        check("t6_glitch_init", init_finish, 1'b1);
        check("t6_glitch_err", load_error, 1'b0);
        check("t6_q", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
